// File: rtl/layer_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : layer_mem_responder
// Purpose  : Avalon-MM slave modelling one word-addressed 16-bit memory window.
//            It adds a programmable number of wait states before each command
//            is accepted and returns read data after a fixed latency.
// Ports    : clk, reset          - rising-edge clock, synchronous active-high reset
//            chipselect, address, byteenable, read_n, write_n, writedata
//                                - Avalon-MM command side (byte address)
//            waitrequest         - low only in the single accept cycle
//            readdatavalid, readdata - one-cycle read response
//            proto_err, addr_err - sticky error flags, cleared by reset only
//            toHexLed            - {rd_count, wr_count} completed accesses
// Revision : 1.0 - initial release
// ============================================================================
module layer_mem_responder #(
    parameter logic [31:0] BASE_ADDR    = 32'd400_000,
    parameter int          DEPTH        = 256,
    parameter int          WAIT_STATES  = 1,
    parameter int          READ_LATENCY = 2,
    parameter logic [15:0] ERR_DATA     = 16'hDEAD
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        chipselect,
    input  logic [31:0] address,
    input  logic [1:0]  byteenable,
    input  logic        read_n,
    input  logic        write_n,
    input  logic [15:0] writedata,
    output logic        waitrequest,
    output logic        readdatavalid,
    output logic [15:0] readdata,
    output logic        proto_err,
    output logic        addr_err,
    output logic [31:0] toHexLed
);

    localparam int          c_IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [32:0] c_SPAN   = 33'(2 * DEPTH);

    localparam logic [2:0]  c_ST_IDLE   = 3'd0;
    localparam logic [2:0]  c_ST_STALL  = 3'd1;
    localparam logic [2:0]  c_ST_ACCEPT = 3'd2;
    localparam logic [2:0]  c_ST_RDWAIT = 3'd3;
    localparam logic [2:0]  c_ST_RESP   = 3'd4;

    logic [2:0]         r_state;
    logic [2:0]         w_next;
    logic [3:0]         r_cnt;
    logic [15:0]        r_mem [DEPTH];
    logic [15:0]        r_rd_buf;
    logic [15:0]        r_rd_count;
    logic [15:0]        r_wr_count;

    logic               w_cmd;
    logic               w_both;
    logic               w_acc;
    logic               w_accept_wr;
    logic               w_accept_rd;
    logic               w_stall_drop;
    logic [32:0]        w_off;
    logic               w_addr_ok;
    logic [c_IDX_W-1:0] w_idx;
    logic [15:0]        w_rd_word;

    assign w_cmd  = chipselect & (~read_n | ~write_n);
    assign w_both = chipselect & ~read_n & ~write_n;

    // 33-bit offset: addresses below the base wrap into bit 32 and therefore
    // fail the span compare, so no separate lower-bound check is needed.
    assign w_off     = {1'b0, address} - {1'b0, BASE_ADDR};
    assign w_addr_ok = ~address[0] && (w_off < c_SPAN);
    assign w_idx     = w_off[c_IDX_W:1];
    assign w_rd_word = w_addr_ok ? r_mem[w_idx] : ERR_DATA;

    assign w_acc       = (r_state == c_ST_ACCEPT) & w_cmd;
    assign w_accept_wr = w_acc & ~w_both & ~write_n;
    assign w_accept_rd = w_acc & ~w_both & ~read_n;

    assign waitrequest   = (r_state != c_ST_ACCEPT);
    assign readdatavalid = (r_state == c_ST_RESP);
    assign toHexLed      = {r_rd_count, r_wr_count};

    always_comb begin
        w_next       = r_state;
        w_stall_drop = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_cmd) begin
                    w_next = (WAIT_STATES == 0) ? c_ST_ACCEPT : c_ST_STALL;
                end
            end
            c_ST_STALL: begin
                // A master that withdraws its command while stalled is a
                // protocol violation; the drop takes priority over the count.
                if (!w_cmd) begin
                    w_next       = c_ST_IDLE;
                    w_stall_drop = 1'b1;
                end else if (r_cnt == 4'(WAIT_STATES - 1)) begin
                    w_next = c_ST_ACCEPT;
                end
            end
            c_ST_ACCEPT: begin
                if (w_accept_rd) begin
                    w_next = (READ_LATENCY > 1) ? c_ST_RDWAIT : c_ST_RESP;
                end else begin
                    w_next = c_ST_IDLE;
                end
            end
            c_ST_RDWAIT: begin
                if (r_cnt == 4'(READ_LATENCY - 2)) begin
                    w_next = c_ST_RESP;
                end
            end
            c_ST_RESP: begin
                w_next = c_ST_IDLE;
            end
            default: begin
                w_next = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_ST_IDLE;
            r_cnt      <= 4'd0;
            r_rd_buf   <= 16'h0000;
            readdata   <= 16'h0000;
            proto_err  <= 1'b0;
            addr_err   <= 1'b0;
            r_rd_count <= 16'h0000;
            r_wr_count <= 16'h0000;
        end else begin
            r_state <= w_next;
            // Cycle counter restarts on every state change.
            r_cnt   <= (w_next != r_state) ? 4'd0 : r_cnt + 4'd1;

            if (w_stall_drop || (w_acc && w_both)) begin
                proto_err <= 1'b1;
            end
            if ((w_accept_wr || w_accept_rd) && !w_addr_ok) begin
                addr_err <= 1'b1;
            end
            if (w_accept_wr) begin
                r_wr_count <= r_wr_count + 16'd1;
            end
            if (r_state == c_ST_RESP) begin
                r_rd_count <= r_rd_count + 16'd1;
            end
            if (w_accept_rd) begin
                r_rd_buf <= w_rd_word;
            end
            // readdata carries the word only during the RESP cycle.
            if (w_next == c_ST_RESP) begin
                readdata <= (r_state == c_ST_ACCEPT) ? w_rd_word : r_rd_buf;
            end else begin
                readdata <= 16'h0000;
            end
        end
    end

    // Memory contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (!reset && w_accept_wr && w_addr_ok) begin
            if (byteenable[0]) begin
                r_mem[w_idx][7:0] <= writedata[7:0];
            end
            if (byteenable[1]) begin
                r_mem[w_idx][15:8] <= writedata[15:8];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_layer_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_layer_mem_responder
// Purpose  : Self-checking bench for layer_mem_responder. Instance 0 uses the
//            default timing (1 wait state, read latency 2); instance 1 uses
//            0 wait states and read latency 1. Expected read responses are
//            queued at accept time and compared when readdatavalid fires.
// Revision : 1.0 - initial release
// ============================================================================
module tb_layer_mem_responder;

    typedef struct {
        bit          wr;
        logic [31:0] a;
        logic [15:0] d;
        logic [1:0]  be;
        logic [15:0] exp;
    } vec_t;

    typedef struct {
        int          sel;
        logic [15:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        cs0, cs1;
    logic [31:0] address;
    logic [1:0]  byteenable;
    logic        read_n, write_n;
    logic [15:0] writedata;
    logic        wr0, rdv0, pe0, ae0;
    logic        wr1, rdv1, pe1, ae1;
    logic [15:0] rd0, rd1;
    logic [31:0] hex0, hex1;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   m_wr  = 0;
    int   m_rd  = 0;
    exp_t q[$];
    exp_t mon_e;
    vec_t vecs[17];

    layer_mem_responder u_dut0 (
        .clk(clk), .reset(reset), .chipselect(cs0), .address(address),
        .byteenable(byteenable), .read_n(read_n), .write_n(write_n),
        .writedata(writedata), .waitrequest(wr0), .readdatavalid(rdv0),
        .readdata(rd0), .proto_err(pe0), .addr_err(ae0), .toHexLed(hex0)
    );

    layer_mem_responder #(.WAIT_STATES(0), .READ_LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset), .chipselect(cs1), .address(address),
        .byteenable(byteenable), .read_n(read_n), .write_n(write_n),
        .writedata(writedata), .waitrequest(wr1), .readdatavalid(rdv1),
        .readdata(rd1), .proto_err(pe1), .addr_err(ae1), .toHexLed(hex1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Response scoreboard: every readdatavalid must match the oldest entry.
    always @(negedge clk) begin
        if (rdv0 || rdv1) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_rdv: rdv0=%b rdv1=%b at cycle %0d, want none", rdv0, rdv1, cyc);
            end else begin
                mon_e = q.pop_front();
                if (((mon_e.sel == 0) ? !rdv0 : !rdv1) ||
                    (((mon_e.sel == 0) ? rd0 : rd1) !== mon_e.data) ||
                    (cyc != mon_e.cyc)) begin
                    bad++;
                    $display("FAIL read_resp: dut%0d data=%h cycle=%0d, want data=%h cycle=%0d",
                             mon_e.sel, (mon_e.sel == 0) ? rd0 : rd1, cyc, mon_e.data, mon_e.cyc);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        m_wr = 0;
        m_rd = 0;
    endtask

    // kind: 0 write, 1 read, 2 read_n and write_n both low
    task automatic bus_op(input int sel, input int kind, input logic [31:0] a,
                          input logic [15:0] d, input logic [1:0] be,
                          input bit push, input logic [15:0] exp, input int exp_lat);
        int   lat;
        bit   acc;
        exp_t e;
        @(posedge clk);
        #1;
        address    = a;
        writedata  = d;
        byteenable = be;
        read_n     = (kind == 0);
        write_n    = (kind == 1);
        if (sel == 0) cs0 = 1'b1; else cs1 = 1'b1;
        lat = 0;
        acc = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!((sel == 0) ? wr0 : wr1)) begin
                acc = 1'b1;
                break;
            end
            lat++;
        end
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: dut%0d waitrequest stuck high, want low within 50 cycles", sel);
        end else begin
            check("accept_latency", lat, exp_lat);
            if (push) begin
                e.sel  = sel;
                e.data = exp;
                e.cyc  = cyc + ((sel == 0) ? 2 : 1);
                q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        cs0     = 1'b0;
        cs1     = 1'b0;
        read_n  = 1'b1;
        write_n = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            if (q.size() == 0) break;
            @(negedge clk);
        end
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL rdv_timeout: %0d responses outstanding, want 0", q.size());
            q.delete();
        end
        @(negedge clk);
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            if (vecs[i].wr) begin
                bus_op(0, 0, vecs[i].a, vecs[i].d, vecs[i].be, 1'b0, 16'h0, 2);
                m_wr++;
            end else begin
                bus_op(0, 1, vecs[i].a, 16'h0, 2'b11, 1'b1, vecs[i].exp, 2);
                drain();
                m_rd++;
            end
        end
        drain();
        check("counters", hex0, {m_rd[15:0], m_wr[15:0]});
    endtask

    task automatic count_rdv(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (rdv0 || rdv1) cnt++;
        end
    endtask

    initial begin
        int n_rdv;
        vecs[0]  = '{1'b1, 32'd400000, 16'h1234, 2'b11, 16'h0000};
        vecs[1]  = '{1'b0, 32'd400000, 16'h0000, 2'b11, 16'h1234};
        vecs[2]  = '{1'b1, 32'd400010, 16'hAAAA, 2'b11, 16'h0000};
        vecs[3]  = '{1'b1, 32'd400010, 16'h55FF, 2'b01, 16'h0000};
        vecs[4]  = '{1'b0, 32'd400010, 16'h0000, 2'b11, 16'hAAFF};
        vecs[5]  = '{1'b1, 32'd400010, 16'h12FF, 2'b10, 16'h0000};
        vecs[6]  = '{1'b0, 32'd400010, 16'h0000, 2'b11, 16'h12FF};
        vecs[7]  = '{1'b1, 32'd400010, 16'h0000, 2'b00, 16'h0000};
        vecs[8]  = '{1'b0, 32'd400010, 16'h0000, 2'b11, 16'h12FF};
        vecs[9]  = '{1'b1, 32'd400510, 16'h7777, 2'b11, 16'h0000};
        vecs[10] = '{1'b0, 32'd399998, 16'h0000, 2'b11, 16'hDEAD};
        vecs[11] = '{1'b0, 32'd400512, 16'h0000, 2'b11, 16'hDEAD};
        vecs[12] = '{1'b0, 32'd400001, 16'h0000, 2'b11, 16'hDEAD};
        vecs[13] = '{1'b1, 32'd399998, 16'hBEEF, 2'b11, 16'h0000};
        vecs[14] = '{1'b1, 32'd400512, 16'hBEEF, 2'b11, 16'h0000};
        vecs[15] = '{1'b0, 32'd400510, 16'h0000, 2'b11, 16'h7777};
        vecs[16] = '{1'b0, 32'd400000, 16'h0000, 2'b11, 16'h1234};

        cs0 = 1'b0; cs1 = 1'b0; address = 32'h0; byteenable = 2'b11;
        read_n = 1'b1; write_n = 1'b1; writedata = 16'h0;
        do_reset();

        // Reset state
        @(negedge clk);
        check("rst_waitrequest", {31'h0, wr0}, 32'h1);
        check("rst_rdv", {31'h0, rdv0}, 32'h0);
        check("rst_readdata", {16'h0, rd0}, 32'h0);
        check("rst_errs", {28'h0, pe0, ae0, pe1, ae1}, 32'h0);
        check("rst_counters", hex0, 32'h0);
        check("rst_counters1", hex1, 32'h0);

        // Basic write/read, byte lanes, then out-of-window accesses
        run_vecs(0, 1);
        check("t1_hex", hex0, 32'h0001_0001);
        run_vecs(2, 9);
        check("addr_err_clean", {31'h0, ae0}, 32'h0);
        run_vecs(10, 16);
        check("addr_err_set", {31'h0, ae0}, 32'h1);
        check("proto_err_clean", {31'h0, pe0}, 32'h0);

        // 200 consecutive words, written then read back
        do_reset();
        for (int i = 0; i < 200; i++)
            bus_op(0, 0, 32'd400000 + 32'(2 * i), 16'(i + 1), 2'b11, 1'b0, 16'h0, 2);
        for (int i = 0; i < 200; i++) begin
            bus_op(0, 1, 32'd400000 + 32'(2 * i), 16'h0, 2'b11, 1'b1, 16'(i + 1), 2);
            drain();
        end
        check("t4_hex", hex0, 32'h00C8_00C8);

        // Command withdrawn during the stall
        do_reset();
        @(posedge clk);
        #1;
        address = 32'd400000; cs0 = 1'b1; read_n = 1'b0;
        @(posedge clk);
        #1 read_n = 1'b1;
        @(posedge clk);
        #1 cs0 = 1'b0;
        @(negedge clk);
        check("stall_drop_proto", {31'h0, pe0}, 32'h1);
        bus_op(0, 0, 32'd400000, 16'h0101, 2'b11, 1'b0, 16'h0, 2);
        check("after_drop_hex", hex0, 32'h0000_0001);

        // read_n and write_n both low: accepted but nothing performed
        do_reset();
        bus_op(0, 2, 32'd400000, 16'hFFFF, 2'b11, 1'b0, 16'h0, 2);
        count_rdv(6, n_rdv);
        check("both_low_no_rdv", n_rdv, 0);
        check("both_low_proto", {31'h0, pe0}, 32'h1);
        check("both_low_hex", hex0, 32'h0);
        bus_op(0, 1, 32'd400000, 16'h0, 2'b11, 1'b1, 16'h0101, 2);
        drain();

        // Reset while a read is waiting in RDWAIT
        bus_op(0, 1, 32'd400000, 16'h0, 2'b11, 1'b0, 16'h0, 2);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        m_wr = 0;
        m_rd = 0;
        count_rdv(6, n_rdv);
        check("rdwait_reset_no_rdv", n_rdv, 0);
        check("rdwait_reset_hex", hex0, 32'h0);
        check("rdwait_reset_proto", {31'h0, pe0}, 32'h0);

        // Zero wait states, latency 1
        bus_op(1, 0, 32'd400020, 16'h4242, 2'b11, 1'b0, 16'h0, 1);
        bus_op(1, 1, 32'd400020, 16'h0, 2'b11, 1'b1, 16'h4242, 1);
        drain();
        bus_op(1, 1, 32'd400003, 16'h0, 2'b11, 1'b1, 16'hDEAD, 1);
        drain();
        check("fast_hex", hex1, 32'h0002_0001);
        check("fast_addr_err", {31'h0, ae1}, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
